cfg_connection_block: RTL and testbench

Scan-configured successor to the unidirectional data connection block. It routes a parametrised set of north/south routing tracks into a logic block's data inputs, and logic-block data outputs back onto the tracks. Configuration is loaded through a serial shift chain into a shadow register and committed atomically, with bit counting and error flagging. An optional registered input path is provided. It sits between a routing channel and a logic tile, chained with its neighbours on `cfg_in`/`cfg_out`.

---
 rtl/cfg_connection_block.sv | 172 +++++++++++++++++
 tb/tb_cfg_connection_block.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_connection_block.sv
// Scan-configured connection block: routes N/S tracks into logic-block inputs and
// logic-block outputs onto the tracks, configured via a counted serial shadow chain.
module cfg_connection_block #(
    parameter int W       = 16,
    parameter int WW      = 4,
    parameter int DATAIN  = 4,
    parameter int DATAOUT = 3,
    parameter int REG_IN  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [W-1:0]          north_in,
    input  logic [W-1:0]          south_in,
    output logic [W-1:0]          north_out,
    output logic [W-1:0]          south_out,
    output logic [WW*DATAIN-1:0]  data_input,
    input  logic [WW*DATAOUT-1:0] data_output,
    input  logic                  cfg_en,
    input  logic                  cfg_in,
    output logic                  cfg_out,
    input  logic                  cfg_commit,
    output logic                  cfg_full,
    output logic                  cfg_err
);

    localparam int NSEG        = 2*W/WW;
    localparam int SEL_PER_IN  = $clog2(NSEG);
    localparam int SEL_PER_OUT = $clog2(DATAOUT+1);
    localparam int NIN         = DATAIN*WW;
    localparam int IN_BITS     = SEL_PER_IN*NIN;
    localparam int CFG_BITS    = IN_BITS + SEL_PER_OUT*2*W;
    localparam int CNT_W       = $clog2(CFG_BITS+1);
    localparam int CI_W        = $clog2(2*W);
    localparam int OI_W        = $clog2(WW*DATAOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOADING,
        S_FULL,
        S_OVER
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic                w_shift;
    logic                w_load_active;
    logic [CFG_BITS-1:0] r_shadow;
    logic [CFG_BITS-1:0] r_active;
    logic [2*W-1:0]      w_cand;
    logic [NIN-1:0]      w_din;

    // Commit has priority over a same-cycle shift: it sees the pre-shift state
    // and shadow, and the incoming shift bit is dropped.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_err_nxt     = r_err;
        w_shift       = 1'b0;
        w_load_active = 1'b0;
        if (cfg_commit) begin
            w_state_nxt = S_EMPTY;
            w_cnt_nxt   = '0;
            if (r_state == S_FULL) begin
                w_load_active = 1'b1;
                w_err_nxt     = 1'b0;
            end else begin
                w_err_nxt     = 1'b1;
            end
        end else if (cfg_en) begin
            w_shift = 1'b1;
            case (r_state)
                S_EMPTY, S_LOADING: begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_state_nxt = ((r_cnt + 1'b1) == CNT_LAST) ? S_FULL : S_LOADING;
                end
                S_FULL:  w_state_nxt = S_OVER;
                default: w_state_nxt = S_OVER;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            if (w_shift) begin
                r_shadow <= {cfg_in, r_shadow[CFG_BITS-1:1]};
            end
            if (w_load_active) begin
                r_active <= r_shadow;
            end
        end
    end

    assign w_cand = {south_in, north_in};

    // Input routing: each data-input bit picks a WW-wide segment of the candidate
    // bus and takes the bit at its own position within the word.
    always_comb begin : p_in_route
        logic [SEL_PER_IN-1:0] sel;
        logic [CI_W-1:0]       ci;
        w_din = '0;
        for (int b = 0; b < NIN; b++) begin
            sel = r_active[b*SEL_PER_IN +: SEL_PER_IN];
            ci  = CI_W'(int'(sel)*WW + (b % WW));
            if (int'(sel) < NSEG) begin
                w_din[b] = w_cand[ci];
            end
        end
    end

    // Out-of-range output selects fall back to pass-through.
    always_comb begin : p_out_route
        logic [SEL_PER_OUT-1:0] nsel;
        logic [SEL_PER_OUT-1:0] ssel;
        logic [OI_W-1:0]        ni;
        logic [OI_W-1:0]        si;
        north_out = south_in;
        south_out = north_in;
        for (int t = 0; t < W; t++) begin
            nsel = r_active[IN_BITS + t*SEL_PER_OUT +: SEL_PER_OUT];
            ssel = r_active[IN_BITS + (W+t)*SEL_PER_OUT +: SEL_PER_OUT];
            ni   = OI_W'((t % WW) + (int'(nsel) - 1)*WW);
            si   = OI_W'((t % WW) + (int'(ssel) - 1)*WW);
            if (nsel != '0 && int'(nsel) <= DATAOUT) begin
                north_out[t] = data_output[ni];
            end
            if (ssel != '0 && int'(ssel) <= DATAOUT) begin
                south_out[t] = data_output[si];
            end
        end
    end

    generate
        if (REG_IN != 0) begin : g_reg_in
            logic [NIN-1:0] r_din;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_din <= '0;
                end else begin
                    r_din <= w_din;
                end
            end
            assign data_input = r_din;
        end else begin : g_comb_in
            assign data_input = w_din;
        end
    endgenerate

    assign cfg_out  = r_shadow[0];
    assign cfg_full = (r_state == S_FULL);
    assign cfg_err  = r_err;

endmodule

// File: tb/tb_cfg_connection_block.sv
// Bench for cfg_connection_block: a combinational instance and a registered-input
// instance share all stimulus and are compared every cycle against a behavioural model.
module tb_cfg_connection_block;

    localparam int W        = 16;
    localparam int WW       = 4;
    localparam int DATAIN   = 4;
    localparam int DATAOUT  = 3;
    localparam int SPI      = 3;
    localparam int SPO      = 2;
    localparam int NIN      = WW*DATAIN;
    localparam int IN_BITS  = SPI*NIN;
    localparam int CFG_BITS = IN_BITS + SPO*2*W;

    logic              clk;
    logic              rst_n;
    logic [W-1:0]      ni;
    logic [W-1:0]      si;
    logic [WW*DATAOUT-1:0] dout;
    logic              cfg_en;
    logic              cfg_in;
    logic              cfg_commit;

    logic [W-1:0]   n0, s0, n1, s1;
    logic [NIN-1:0] di0, di1;
    logic           co0, f0, e0, co1, f1, e1;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    cfg_connection_block #(.W(W), .WW(WW), .DATAIN(DATAIN), .DATAOUT(DATAOUT), .REG_IN(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .north_in(ni), .south_in(si),
        .north_out(n0), .south_out(s0), .data_input(di0), .data_output(dout),
        .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_out(co0), .cfg_commit(cfg_commit),
        .cfg_full(f0), .cfg_err(e0)
    );

    cfg_connection_block #(.W(W), .WW(WW), .DATAIN(DATAIN), .DATAOUT(DATAOUT), .REG_IN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .north_in(ni), .south_in(si),
        .north_out(n1), .south_out(s1), .data_input(di1), .data_output(dout),
        .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_out(co1), .cfg_commit(cfg_commit),
        .cfg_full(f1), .cfg_err(e1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit                  m_hist[$];   // last CFG_BITS shifted bits, oldest first
    int                  m_cnt = 0;   // shifts since last commit/reset, unbounded
    logic [CFG_BITS-1:0] m_active = '0;
    logic                m_err = 1'b0;
    logic [NIN-1:0]      m_reg_din = '0;

    function automatic int fld(input logic [CFG_BITS-1:0] a, input int lsb, input int n);
        int v = 0;
        for (int q = 0; q < n; q++) v += int'(a[lsb+q]) << q;
        return v;
    endfunction

    function automatic logic [CFG_BITS-1:0] m_shadow();
        logic [CFG_BITS-1:0] s = '0;
        for (int i = 0; i < CFG_BITS; i++) begin
            int idx = m_hist.size() - (CFG_BITS - i);
            if (idx >= 0) s[i] = m_hist[idx];
        end
        return s;
    endfunction

    function automatic logic [NIN-1:0] m_route_in(input logic [CFG_BITS-1:0] a,
                                                  input logic [W-1:0] n, input logic [W-1:0] s);
        logic [NIN-1:0] r = '0;
        logic [2*W-1:0] cand = {s, n};
        for (int i = 0; i < DATAIN; i++)
            for (int j = 0; j < WW; j++) begin
                int k = fld(a, (i*WW+j)*SPI, SPI);
                if (k < 2*W/WW) r[i*WW+j] = cand[k*WW+j];
            end
        return r;
    endfunction

    function automatic logic [W-1:0] m_route_out(input logic [CFG_BITS-1:0] a, input bit north,
                                                 input logic [W-1:0] n, input logic [W-1:0] s,
                                                 input logic [WW*DATAOUT-1:0] d);
        logic [W-1:0] r;
        for (int t = 0; t < W; t++) begin
            int k = fld(a, IN_BITS + ((north ? 0 : W) + t)*SPO, SPO);
            if (k >= 1 && k <= DATAOUT) r[t] = d[(t % WW) + (k-1)*WW];
            else r[t] = north ? s[t] : n[t];
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hist.delete();
            m_cnt     = 0;
            m_active  = '0;
            m_err     = 1'b0;
            m_reg_din = '0;
        end else begin
            m_reg_din = m_route_in(m_active, ni, si);
            if (cfg_commit) begin
                if (m_cnt == CFG_BITS) begin
                    m_active = m_shadow();
                    m_err    = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
                m_cnt = 0;
            end else if (cfg_en) begin
                m_hist.push_back(cfg_in);
                if (m_hist.size() > CFG_BITS) void'(m_hist.pop_front());
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic [CFG_BITS-1:0] sh;
            sh = m_shadow();
            chk("north_out0", 32'(n0), 32'(m_route_out(m_active, 1'b1, ni, si, dout)));
            chk("south_out0", 32'(s0), 32'(m_route_out(m_active, 1'b0, ni, si, dout)));
            chk("north_out1", 32'(n1), 32'(m_route_out(m_active, 1'b1, ni, si, dout)));
            chk("south_out1", 32'(s1), 32'(m_route_out(m_active, 1'b0, ni, si, dout)));
            chk("data_input0", 32'(di0), 32'(m_route_in(m_active, ni, si)));
            chk("data_input1", 32'(di1), 32'(m_reg_din));
            chk("cfg_out", 32'({co1, co0}), 32'({sh[0], sh[0]}));
            chk("cfg_full", 32'({f1, f0}), (m_cnt == CFG_BITS) ? 32'h3 : 32'h0);
            chk("cfg_err", 32'({e1, e0}), m_err ? 32'h3 : 32'h0);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [CFG_BITS-1:0] build(input int isel, input int nsel, input int ssel);
        logic [CFG_BITS-1:0] c = '0;
        for (int b = 0; b < NIN; b++) c[b*SPI +: SPI] = SPI'(isel);
        for (int t = 0; t < W; t++) begin
            c[IN_BITS + t*SPO +: SPO]     = SPO'(nsel);
            c[IN_BITS + (W+t)*SPO +: SPO] = SPO'(ssel);
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic shift_bits(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            cfg_en = 1'b1;
            cfg_in = v[i];
            tick();
        end
        cfg_en = 1'b0;
        cfg_in = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    logic [CFG_BITS-1:0] cfg_a, cfg_b, cfg_c, cfg_d;

    initial begin
        rst_n = 1'b0; ni = 16'hA5A5; si = 16'h3C3C; dout = 12'hC6E;
        cfg_en = 1'b0; cfg_in = 1'b0; cfg_commit = 1'b0;
        cfg_a = build(5, 2, 2);
        cfg_b = build(1, 3, 3);
        cfg_c = build(2, 1, 2);
        cfg_d = build(2, 1, 0);
        tick(); tick();
        chk("t1_din1_in_reset", 32'(di1), 32'h0);
        rst_n = 1'b1;
        chk_on = 1'b1;

        // 1: reset state is pass-through
        @(negedge clk);
        chk("t1_north_out", 32'(n0), 32'h3C3C);
        chk("t1_south_out", 32'(s0), 32'hA5A5);
        chk("t1_err_full", 32'({e0, f0}), 32'h0);
        chk("t1_din0", 32'(di0), 32'h5555);

        // 2: full load, commit, registered-input latency
        tick();
        shift_bits(cfg_a, CFG_BITS);
        @(negedge clk);
        chk("t2_full_before", 32'(f0), 32'h1);
        tick();
        commit();
        @(negedge clk);
        chk("t2_full_after", 32'(f0), 32'h0);
        chk("t2_din0", 32'(di0), 32'h3333);
        chk("t2_north_out", 32'(n0), 32'h6666);
        chk("t2_south_out", 32'(s0), 32'h6666);
        tick();
        @(negedge clk);
        chk("t2_din1", 32'(di1), 32'h3333);
        tick();
        si = 16'h00F0;
        @(negedge clk);
        chk("t6_din0_now", 32'(di0), 32'hFFFF);
        chk("t6_din1_lag", 32'(di1), 32'h3333);
        @(negedge clk);
        chk("t6_din1_next", 32'(di1), 32'hFFFF);

        // 3: short load rejected, then a correct load clears the error
        tick();
        rst_n = 1'b0; si = 16'h3C3C;
        tick();
        rst_n = 1'b1;
        shift_bits(cfg_b, CFG_BITS-1);
        commit();
        @(negedge clk);
        chk("t3_err_short", 32'(e0), 32'h1);
        chk("t3_passthru", 32'(n0), 32'h3C3C);
        tick();
        shift_bits(cfg_b, CFG_BITS);
        @(negedge clk);
        chk("t3_full", 32'(f0), 32'h1);
        tick();
        commit();
        @(negedge clk);
        chk("t3_err_clear", 32'(e0), 32'h0);
        chk("t3_north_out", 32'(n0), 32'hCCCC);
        chk("t3_din0", 32'(di0), 32'hAAAA);

        // 4: overshift
        tick();
        shift_bits({16'h0000, cfg_c}, CFG_BITS+1);
        @(negedge clk);
        chk("t4_full_over", 32'(f0), 32'h0);
        chk("t4_cfg_out", 32'(co0), 32'h1);
        tick();
        commit();
        @(negedge clk);
        chk("t4_err", 32'(e0), 32'h1);
        chk("t4_active_kept", 32'(n0), 32'hCCCC);

        // 6: reset mid-load clears everything immediately
        tick();
        shift_bits(cfg_a, 50);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_err_full", 32'({e0, f0, e1, f1}), 32'h0);
        chk("t6_rst_north", 32'(n0), 32'h3C3C);
        chk("t6_rst_south", 32'(s0), 32'hA5A5);
        chk("t6_rst_din1", 32'(di1), 32'h0);
        chk("t6_rst_din0", 32'(di0), 32'h5555);
        tick();
        rst_n = 1'b1;

        // 5: commit and shift together in FULL
        ni = 16'h1234;
        tick();
        shift_bits(cfg_d, CFG_BITS);
        cfg_en = 1'b1; cfg_in = 1'b1; cfg_commit = 1'b1;
        tick();
        cfg_en = 1'b0; cfg_in = 1'b0; cfg_commit = 1'b0;
        @(negedge clk);
        chk("t5_full", 32'(f0), 32'h0);
        chk("t5_err", 32'(e0), 32'h0);
        chk("t5_bit_lost", 32'(co0), 32'h0);
        chk("t5_din0", 32'(di0), 32'h2222);
        chk("t5_north_out", 32'(n0), 32'hEEEE);
        chk("t5_south_out", 32'(s0), 32'h1234);
        tick();
        shift_bits(cfg_b, CFG_BITS-1);
        @(negedge clk);
        chk("t5_not_full_yet", 32'(f0), 32'h0);
        tick();
        shift_bits(128'h1, 1);
        @(negedge clk);
        chk("t5_full_from_empty", 32'(f0), 32'h1);

        tick();
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
